uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (tx_data / tx_start / tx_busy) between N byte-producing requesters, e.g. command echo, status reporter and debug dump.
- Uses round-robin arbitration and a per-requester req/ack handshake.
- Sequences every byte through the transmitter: start pulse, wait for busy to rise, wait for busy to fall.
- Adds a start-timeout watchdog and a sent-byte counter for bring-up LEDs and 7-segment displays.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte requesters.
// Each granted byte is sequenced as start pulse, busy rise, busy fall, with a start watchdog.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     ack,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [IDX_W-1:0] grant_idx,
  output logic             active,
  output logic             timeout_err,
  output logic [15:0]      tx_count
);

  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N-1:0]       ack_d;
  logic [7:0]         tx_data_d;
  logic               tx_start_d;
  logic [IDX_W-1:0]   grant_idx_d;
  logic               active_d;
  logic               timeout_err_d;
  logic [15:0]        tx_count_d;

  // Returns {found, index}. Scanning from the far end down lets the requester
  // closest to the pointer overwrite the others, so no early exit is needed.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  logic [IDX_W:0]   pick;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [7:0]       pick_data;
  logic [N-1:0]     pick_onehot;

  assign pick       = rr_pick(req, ptr_q);
  assign pick_found = pick[IDX_W];
  assign pick_idx   = pick[IDX_W-1:0];

  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_data      = req_data[8*i +: 8];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default before the case (hold for state,
    // clear for pulses) so no branch leaves one unassigned and infers a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    timer_d       = timer_q;
    ack_d         = '0;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    tx_data_d     = tx_data;
    grant_idx_d   = grant_idx;
    active_d      = active;
    tx_count_d    = tx_count;

    case (state_q)
      IDLE: begin
        // A busy transmitter here belongs to someone else or is still draining.
        if (!tx_busy && pick_found) begin
          tx_data_d   = pick_data;
          tx_start_d  = 1'b1;
          ack_d       = pick_onehot;
          grant_idx_d = pick_idx;
          active_d    = 1'b1;
          ptr_d       = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
          timer_d     = '0;
          state_d     = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          // The byte is dropped; its ack already went out and it is not retried.
          timeout_err_d = 1'b1;
          active_d      = 1'b0;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          tx_count_d = tx_count + 16'd1;
          active_d   = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      ack         <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_idx   <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      tx_count    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      ack         <= ack_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      grant_idx   <= grant_idx_d;
      active      <= active_d;
      timeout_err <= timeout_err_d;
      tx_count    <= tx_count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, multi-cycle corner
// sequences, and randomized traffic against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int T     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic [IDX_W-1:0] grant_idx;
  logic             active;
  logic             timeout_err;
  logic [15:0]      tx_count;

  logic [7:0] rq_data [N];
  logic       uart_busy = 1'b0;
  logic       ext_busy  = 1'b0;
  logic       busy_at_edge = 1'b0;
  int         cyc = 0;

  assign tx_busy = uart_busy | ext_busy;

  always_comb begin
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = rq_data[i];
  end

  uart_tx_arbiter #(.N(N), .IDX_W(IDX_W), .BUSY_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .grant_idx   (grant_idx),
    .active      (active),
    .timeout_err (timeout_err),
    .tx_count    (tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= tx_busy;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART model: after a start pulse, waits u_delay negedges, then holds busy
  // for u_len negedges. In random mode it draws its own timing per byte.
  int u_delay = 2;
  int u_len   = 10;
  bit u_never = 1'b0;
  bit u_rand  = 1'b0;
  bit u_clr   = 1'b0;
  bit u_last_never = 1'b0;

  initial begin
    int phase;
    int cnt;
    int cur_delay;
    int cur_len;
    phase = 0;
    cnt = 0;
    cur_delay = 1;
    cur_len = 1;
    forever begin
      @(negedge clk);
      if (u_clr) begin
        uart_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (tx_start) begin
               if (u_rand) begin
                 u_last_never = ($urandom_range(0, 7) == 0);
                 cur_delay    = $urandom_range(1, 4);
                 cur_len      = $urandom_range(1, 6);
               end else begin
                 u_last_never = u_never;
                 cur_delay    = u_delay;
                 cur_len      = u_len;
               end
               if (!u_last_never) begin
                 cnt = cur_delay;
                 phase = 1;
               end
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 uart_busy = 1'b1;
                 cnt = cur_len;
                 phase = 2;
               end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin
                 uart_busy = 1'b0;
                 phase = 0;
               end
             end
        endcase
      end
    end
  end

  // Reference round-robin choice: first requester at or after the pointer.
  function automatic int rr_expect(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < budget);
    check({name, "_ack_seen"}, 32'(|ack), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (active !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 32'(active), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ack"},         32'(ack), 0);
    check({name, "_tx_data"},     32'(tx_data), 0);
    check({name, "_tx_start"},    32'(tx_start), 0);
    check({name, "_grant_idx"},   32'(grant_idx), 0);
    check({name, "_active"},      32'(active), 0);
    check({name, "_timeout_err"}, 32'(timeout_err), 0);
    check({name, "_tx_count"},    32'(tx_count), 0);
  endtask

  // One full byte with req held as given: grant details, single-cycle pulse, completion.
  task automatic do_txn(input string name, input logic [N-1:0] r, input int w,
                        input logic [7:0] data, input int cnt);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[w] = 1'b1;
    req = r;
    wait_ack(name, 40);
    check({name, "_ack"},       32'(ack), 32'(onehot));
    check({name, "_tx_start"},  32'(tx_start), 1);
    check({name, "_tx_data"},   32'(tx_data), 32'(data));
    check({name, "_grant_idx"}, 32'(grant_idx), w);
    check({name, "_active"},    32'(active), 1);
    @(negedge clk);
    check({name, "_pulse_end"}, 32'({tx_start, ack}), 0);
    wait_idle(name, 60);
    check({name, "_tx_count"},  32'(tx_count), cnt);
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           w;
    logic [7:0]   data;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int early;
    int t_start;
    int exp_cnt;
    int mptr;
    int n_grants;
    int n_timeouts;
    logic [N-1:0] prev_req;
    logic         prev_active;

    tbl[0]  = '{4'b1111, 0, 8'h10};
    tbl[1]  = '{4'b1111, 1, 8'h20};
    tbl[2]  = '{4'b1111, 2, 8'h30};
    tbl[3]  = '{4'b1111, 3, 8'h40};
    tbl[4]  = '{4'b1111, 0, 8'h10};
    tbl[5]  = '{4'b1111, 1, 8'h20};
    tbl[6]  = '{4'b1111, 2, 8'h30};
    tbl[7]  = '{4'b1111, 3, 8'h40};
    tbl[8]  = '{4'b1010, 1, 8'h20};
    tbl[9]  = '{4'b1010, 3, 8'h40};
    tbl[10] = '{4'b1010, 1, 8'h20};
    tbl[11] = '{4'b0011, 0, 8'h10};
    tbl[12] = '{4'b1000, 3, 8'h40};
    tbl[13] = '{4'b0110, 1, 8'h20};
    tbl[14] = '{4'b0100, 2, 8'h30};

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) rq_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Single byte from requester 0.
    rst = 1'b0;
    rq_data[0] = 8'h41;
    req = 4'b0001;
    @(negedge clk);
    check("single_tx_start",  32'(tx_start), 1);
    check("single_ack",       32'(ack), 32'h1);
    check("single_tx_data",   32'(tx_data), 32'h41);
    check("single_grant_idx", 32'(grant_idx), 0);
    check("single_active",    32'(active), 1);
    req = '0;
    @(negedge clk);
    check("single_pulse_end", 32'({tx_start, ack}), 0);
    check("single_active_hold", 32'(active), 1);
    wait_idle("single", 40);
    check("single_tx_count", 32'(tx_count), 1);

    // Transmitter never answers; pointer now at 1, so requester 1 wins.
    for (int i = 0; i < N; i++) rq_data[i] = 8'(8'h10 * (i + 1));
    u_never = 1'b1;
    req = 4'b1110;
    wait_ack("to", 10);
    check("to_grant_idx", 32'(grant_idx), 1);
    t_start = cyc;
    req = 4'b1100;
    early = 0;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      if (k == 1) u_never = 1'b0;
      if (k < T) early = early | int'(timeout_err);
    end
    check("to_no_early_pulse", early, 0);
    check("to_pulse",          32'(timeout_err), 1);
    check("to_delay",          cyc - t_start, T);
    check("to_active_low",     32'(active), 0);
    check("to_tx_count",       32'(tx_count), 1);
    @(negedge clk);
    check("to_next_ack",       32'(ack), 32'h4);
    check("to_next_grant_idx", 32'(grant_idx), 2);
    check("to_pulse_cleared",  32'(timeout_err), 0);
    req = 4'b1000;
    wait_idle("to_next", 60);
    check("to_next_tx_count",  32'(tx_count), 2);

    // Reset while the UART is mid-byte.
    wait_ack("rst_txn", 10);
    check("rst_txn_grant_idx", 32'(grant_idx), 3);
    req = '0;
    early = 0;
    while (!busy_at_edge && early < 20) begin
      @(negedge clk);
      early++;
    end
    check("rst_txn_busy_seen", 32'(busy_at_edge), 1);
    @(negedge clk);
    check("rst_txn_active", 32'(active), 1);
    rst = 1'b1;
    u_clr = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    u_clr = 1'b0;

    // Table: continuous 4-way round robin, sparse patterns, pointer wrap.
    u_len = 4;
    for (int i = 0; i < 15; i++) begin
      do_txn($sformatf("tbl%0d", i), tbl[i].req, tbl[i].w, tbl[i].data, i + 1);
    end

    // External owner holds busy; grant comes the cycle after it drops.
    ext_busy = 1'b1;
    req = 4'b0100;
    early = 0;
    repeat (5) begin
      @(negedge clk);
      early = early | int'(tx_start);
    end
    check("ext_no_start", early, 0);
    ext_busy = 1'b0;
    @(negedge clk);
    check("ext_tx_start",  32'(tx_start), 1);
    check("ext_grant_idx", 32'(grant_idx), 2);
    check("ext_ack",       32'(ack), 32'h4);
    req = '0;
    wait_idle("ext", 40);
    check("ext_tx_count",  32'(tx_count), 16);

    // Randomized traffic against the transaction-level model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u_rand = 1'b1;
    mptr = 0;
    exp_cnt = 0;
    n_grants = 0;
    n_timeouts = 0;
    prev_req = '0;
    prev_active = 1'b0;
    t_start = cyc;
    for (int c = 0; c < 4000; c++) begin
      logic exp_grant;
      int   w;
      @(negedge clk);
      // Idle (active low) and a free transmitter at the edge must grant any pending request.
      exp_grant = !prev_active && !busy_at_edge && (prev_req != '0);
      check("rnd_grant_when", 32'(|ack), 32'(exp_grant));
      check("rnd_start_is_ack", 32'(tx_start), 32'(|ack));
      if (exp_grant && ack != '0) begin
        logic [N-1:0] onehot;
        w = rr_expect(prev_req, mptr);
        onehot = '0;
        onehot[w] = 1'b1;
        check("rnd_grant_idx", 32'(grant_idx), w);
        check("rnd_ack",       32'(ack), 32'(onehot));
        check("rnd_tx_data",   32'(tx_data), 32'(rq_data[w]));
        mptr = (w + 1) % N;
        n_grants++;
        t_start = cyc;
        req[w] = 1'b0;
      end
      if (prev_active && !active) begin
        if (timeout_err) begin
          n_timeouts++;
          check("rnd_timeout_expected", 32'(u_last_never), 1);
          check("rnd_timeout_delay", cyc - t_start, T);
        end else begin
          exp_cnt++;
          check("rnd_done_expected", 32'(u_last_never), 0);
        end
        check("rnd_tx_count", 32'(tx_count), exp_cnt);
      end
      if (c < 3000) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            rq_data[i] = 8'($urandom);
            req[i] = 1'b1;
          end
        end
      end else if (req == '0 && active == 1'b0) begin
        break;
      end
      prev_req = req;
      prev_active = active;
    end
    check("rnd_drained_req",    32'(req), 0);
    check("rnd_drained_active", 32'(active), 0);
    check("rnd_final_tx_count", 32'(tx_count), exp_cnt);
    check("rnd_enough_grants",  32'(n_grants >= 50), 1);
    check("rnd_grants_accounted", n_grants, exp_cnt + n_timeouts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
